// File: rtl/sram_ctrl_pkg.sv
// ============================================================================
//  Module      : sram_ctrl_pkg
//  Description : Shared types and constants for the async SRAM controller:
//                access-sequencer state encoding, bus widths, port indices.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package sram_ctrl_pkg;

  localparam int N_SRAM_A  = 17;  // halfword address width
  localparam int N_SRAM_DQ = 16;  // data width
  localparam int W_WAIT    = 4;   // wait-state config field width

  localparam int PORT_CPU  = 0;   // p0: processor bus bridge
  localparam int PORT_DMA  = 1;   // p1: display/LCD DMA

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_TURN     = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_HOLD  = 3'd5
  } sram_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/sram_ctrl_arb.sv
// ============================================================================
//  Module      : sram_ctrl_arb
//  Description : Two-way grant logic for the SRAM controller. Produces a
//                one-hot grant only when the sequencer can accept a command.
//                Default: fixed priority, DMA (p1) over CPU (p0).
//                SRAM_CTRL_ROUND_ROBIN_EN: round-robin on contention, with a
//                last-granted flop that resets to p0 so p1 wins first.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_ctrl_arb
  import sram_ctrl_pkg::*;
(
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] req_i,
  input  logic       grant_allowed_i,
  output logic [1:0] grant_o
);

`ifdef SRAM_CTRL_ROUND_ROBIN_EN
  logic last_dma_q;  // 1 = DMA port received the most recent grant

  // Contention goes to the port not served last; a lone requester always wins
  always_comb begin
    grant_o = 2'b00;
    if (grant_allowed_i) begin
      if (req_i[PORT_DMA] && req_i[PORT_CPU]) begin
        if (last_dma_q) grant_o[PORT_CPU] = 1'b1;
        else            grant_o[PORT_DMA] = 1'b1;
      end else begin
        grant_o = req_i;
      end
    end
  end

  // Remember which port was granted last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_dma_q <= 1'b0;
    else if (|grant_o) last_dma_q <= grant_o[PORT_DMA];
  end
`else
  // Fixed priority: DMA first, CPU only when DMA is silent
  always_comb begin
    grant_o = 2'b00;
    if (grant_allowed_i) begin
      if (req_i[PORT_DMA])      grant_o[PORT_DMA] = 1'b1;
      else if (req_i[PORT_CPU]) grant_o[PORT_CPU] = 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/sram_ctrl.sv
// ============================================================================
//  Module      : sram_ctrl
//  Description : Sequencing controller for the 16-bit async SRAM pads, shared
//                between the CPU bridge (p0) and the display DMA (p1).
//                All pad outputs, rdata and rvalid are registered; the pad
//                registers are decoded from the current sequencer state, so
//                the pads trail the internal state by one cycle.
//                Optional macro SRAM_CTRL_ROUND_ROBIN_EN selects round-robin
//                arbitration instead of fixed p1-over-p0 priority.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_ctrl #(
  parameter int N_SRAM_A  = sram_ctrl_pkg::N_SRAM_A,
  parameter int N_SRAM_DQ = sram_ctrl_pkg::N_SRAM_DQ,
  parameter int W_WAIT    = sram_ctrl_pkg::W_WAIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W_WAIT-1:0]    cfg_rd_wait,
  input  logic [W_WAIT-1:0]    cfg_wr_wait,
  input  logic                 p0_req,
  output logic                 p0_ack,
  input  logic [N_SRAM_A-1:0]  p0_addr,
  input  logic                 p0_write,
  input  logic [N_SRAM_DQ-1:0] p0_wdata,
  output logic                 p0_rvalid,
  input  logic                 p1_req,
  output logic                 p1_ack,
  input  logic [N_SRAM_A-1:0]  p1_addr,
  input  logic                 p1_write,
  input  logic [N_SRAM_DQ-1:0] p1_wdata,
  output logic                 p1_rvalid,
  output logic [N_SRAM_DQ-1:0] rdata,
  output logic [N_SRAM_A-1:0]  padout_sram_a,
  output logic [N_SRAM_DQ-1:0] padout_sram_dq,
  output logic [N_SRAM_DQ-1:0] padoe_sram_dq,
  input  logic [N_SRAM_DQ-1:0] padin_sram_dq,
  output logic                 padout_sram_cs_n,
  output logic                 padout_sram_oe_n,
  output logic                 padout_sram_we_n
);

  import sram_ctrl_pkg::*;

  sram_ctrl_state_t      state_q, state_d;
  logic [W_WAIT-1:0]     cnt_q, cnt_d;
  logic [N_SRAM_A-1:0]   addr_q;
  logic [N_SRAM_DQ-1:0]  wdata_q;
  logic                  port_q;         // 1 = current access belongs to p1
  logic [1:0]            ack_q;
  logic [1:0]            rvalid_q;
  logic [N_SRAM_DQ-1:0]  rdata_q;
  logic                  rd_last_q, rd_last_d;
  logic                  rd_port_q;

  logic [N_SRAM_A-1:0]   a_q, a_d;
  logic [N_SRAM_DQ-1:0]  dq_q, dq_d;
  logic                  dqoe_q, dqoe_d;
  logic                  cs_n_q, cs_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;

  logic [1:0]            req_eff;
  logic [1:0]            grant;
  logic                  grant_allowed;
  logic                  granted;
  logic                  gnt_port;
  logic                  gnt_write;

  // A request is still visible during its own ack cycle; mask it so it is
  // not granted twice when a grant slot coincides with the ack.
  assign req_eff       = {p1_req & ~ack_q[PORT_DMA], p0_req & ~ack_q[PORT_CPU]};
  assign grant_allowed = (state_q == ST_IDLE) || (state_q == ST_WR_HOLD) ||
                         ((state_q == ST_RD) && (cnt_q == '0));
  assign granted       = |grant;
  assign gnt_port      = grant[PORT_DMA];
  assign gnt_write     = gnt_port ? p1_write : p0_write;

  sram_ctrl_arb u_arb (
`ifdef SRAM_CTRL_ROUND_ROBIN_EN
    .clk             (clk),
    .rst_n           (rst_n),
`endif
    .req_i           (req_eff),
    .grant_allowed_i (grant_allowed),
    .grant_o         (grant)
  );

  // Wait counter: loaded at grant from the config sampled then, counts down in RD/WR_PULSE
  always_comb begin
    cnt_d = cnt_q;
    if (granted)
      cnt_d = gnt_write ? cfg_wr_wait : cfg_rd_wait;
    else if (((state_q == ST_RD) || (state_q == ST_WR_PULSE)) && (cnt_q != '0))
      cnt_d = cnt_q - W_WAIT'(1);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (granted) state_d = gnt_write ? ST_WR_SETUP : ST_RD;
      ST_RD: begin
        if (cnt_q == '0) begin
          if (granted) state_d = gnt_write ? ST_TURN : ST_RD;
          else         state_d = ST_IDLE;
        end
      end
      ST_TURN:     state_d = ST_WR_SETUP;
      ST_WR_SETUP: state_d = ST_WR_PULSE;
      ST_WR_PULSE: if (cnt_q == '0) state_d = ST_WR_HOLD;
      ST_WR_HOLD: begin
        if (granted) state_d = gnt_write ? ST_WR_SETUP : ST_RD;
        else         state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM output decode: next pad values from the current state; DQ drive only
  // in write states, so it can never overlap the RD-only oe_n low
  always_comb begin
    cs_n_d    = (state_q == ST_IDLE);
    oe_n_d    = (state_q != ST_RD);
    we_n_d    = (state_q != ST_WR_PULSE);
    dqoe_d    = (state_q == ST_WR_SETUP) || (state_q == ST_WR_PULSE) ||
                (state_q == ST_WR_HOLD);
    a_d       = (state_q == ST_IDLE) ? a_q : addr_q;
    dq_d      = dqoe_d ? wdata_q : dq_q;
    rd_last_d = (state_q == ST_RD) && (cnt_q == '0);
  end

  // Command capture at grant, ack pulse and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 2'b00;
      cnt_q   <= '0;
      port_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      ack_q <= grant;
      cnt_q <= cnt_d;
      if (granted) begin
        port_q  <= gnt_port;
        addr_q  <= gnt_port ? p1_addr  : p0_addr;
        wdata_q <= gnt_port ? p1_wdata : p0_wdata;
      end
    end
  end

  // Pad output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      we_n_q <= 1'b1;
      dqoe_q <= 1'b0;
      a_q    <= '0;
      dq_q   <= '0;
    end else begin
      cs_n_q <= cs_n_d;
      oe_n_q <= oe_n_d;
      we_n_q <= we_n_d;
      dqoe_q <= dqoe_d;
      a_q    <= a_d;
      dq_q   <= dq_d;
    end
  end

  // Read return: sample DQ at the edge ending the last pad-level RD cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_last_q <= 1'b0;
      rd_port_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 2'b00;
    end else begin
      rd_last_q <= rd_last_d;
      rd_port_q <= port_q;
      if (rd_last_q) rdata_q <= padin_sram_dq;
      rvalid_q  <= rd_last_q ? (rd_port_q ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  assign p0_ack           = ack_q[PORT_CPU];
  assign p1_ack           = ack_q[PORT_DMA];
  assign p0_rvalid        = rvalid_q[PORT_CPU];
  assign p1_rvalid        = rvalid_q[PORT_DMA];
  assign rdata            = rdata_q;
  assign padout_sram_a    = a_q;
  assign padout_sram_dq   = dq_q;
  assign padoe_sram_dq    = {N_SRAM_DQ{dqoe_q}};
  assign padout_sram_cs_n = cs_n_q;
  assign padout_sram_oe_n = oe_n_q;
  assign padout_sram_we_n = we_n_q;

endmodule

`default_nettype wire

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Sequencing controller for the 16-bit parallel async SRAM pads.
- Shares the SRAM between two requesters:
  - p0: processor bus bridge.
  - p1: display/LCD DMA, higher priority by default.
- Generates registered address, data, output-enable and strobe signals with programmable wait states, and returns read data.
- Sits in chip_core between the bus fabric and the SRAM pad signals.

Parameters:
- N_SRAM_A, 17: address width in halfwords.
- N_SRAM_DQ, 16: data width.
- W_WAIT, 4: width of the wait-state config fields.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- cfg_rd_wait / cfg_wr_wait  input  W_WAIT each  extra read cycles / extra WE-low cycles.
- p0_req / p1_req  input  1 each  request; held until acked.
- p0_ack / p1_ack  output  1 each  one-cycle pulse; command captured this cycle.
- p0_addr / p1_addr  input  N_SRAM_A each  halfword address.
- p0_write / p1_write  input  1 each  1 = write, 0 = read.
- p0_wdata / p1_wdata  input  N_SRAM_DQ each  write data.
- p0_rvalid / p1_rvalid  output  1 each  one-cycle read-data-valid pulse.
- rdata  output  N_SRAM_DQ  read data, shared; valid with either rvalid.
- padout_sram_a  output  N_SRAM_A  address to pads.
- padout_sram_dq  output  N_SRAM_DQ  write data to pads.
- padoe_sram_dq  output  N_SRAM_DQ  per-bit DQ output enable; all bits identical.
- padin_sram_dq  input  N_SRAM_DQ  DQ from pads.
- padout_sram_cs_n / padout_sram_oe_n / padout_sram_we_n  output  1 each  strobes, active-low.

Behaviour:
- All pad outputs, rdata and rvalid come straight from flops; no combinational path from any input to a pad output.
- Reset values:
  - cs_n = oe_n = we_n = 1.
  - padoe_sram_dq = 0, padout_sram_a = 0, padout_sram_dq = 0.
  - rdata = 0; acks and rvalids = 0.
  - FSM in IDLE.
- FSM states: IDLE, RD, TURN, WR_SETUP, WR_PULSE, WR_HOLD.
- Grant is evaluated only in IDLE, in the last RD cycle and in WR_HOLD. When granted:
  - ack pulses for that port.
  - addr, write and wdata are latched.
  - Wait counter loads from cfg_rd_wait or cfg_wr_wait, sampled at grant. A config change mid-access has no effect on that access.
- IDLE: all strobes high, DQ not driven.
- RD: cs_n = 0, oe_n = 0, address driven.
  - Lasts cfg_rd_wait+1 cycles.
  - padin_sram_dq is sampled into rdata at the edge ending the last RD cycle; that port's rvalid is high the following cycle.
- Next state after the last RD cycle:
  - Granted read: RD back-to-back; cs_n and oe_n stay low, address changes.
  - Granted write: TURN.
  - No grant: IDLE.
- TURN: exactly 1 cycle with cs_n = 0, oe_n = 1, DQ not driven. Then WR_SETUP.
- WR_SETUP: 1 cycle; cs_n = 0, address and DQ driven, we_n = 1.
- WR_PULSE: cfg_wr_wait+1 cycles with we_n = 0.
- WR_HOLD: 1 cycle; we_n = 1, address and DQ still driven. Then:
  - Granted write: WR_SETUP.
  - Granted read: RD, with DQ released at entry (padoe_sram_dq = 0 together with oe_n = 0).
  - No grant: IDLE, cs_n = 1.
- padoe_sram_dq is never high while oe_n = 0.
- A write produces an ack only; no rvalid.
- Latency: a read granted from IDLE with cfg_rd_wait = 0 gives rvalid 2 cycles after ack.
- Arbitration is fixed priority, p1 over p0. p0 can starve under continuous p1 traffic.
- Simultaneous requests: only one ack per cycle.
- Async reset mid-access: immediately returns to reset values (strobes high, DQ released). Any rvalid still owed is dropped.

Optional Feature:
- Macro: SRAM_CTRL_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. When both ports request, grant the port not granted last; a lone requester is always granted. The last-granted flop resets to p0, so p1 wins the first contention.
- Undefined: fixed priority, p1 over p0; the last-granted flop is not instantiated.

Decomposition:
- Package sram_ctrl_pkg:
  - State enum sram_ctrl_state_t.
  - Width constants W_WAIT, N_SRAM_A, N_SRAM_DQ.
  - Port index constants PORT_CPU = 0, PORT_DMA = 1.
- Sub-module sram_ctrl_arb: 2-way grant logic.
  - Fixed-priority or round-robin, selected by the macro.
  - Inputs: req[1:0], grant_allowed. Output: one-hot grant.

Test Plan:
- p0 read addr 0x1ABCD, cfg_rd_wait = 2, SRAM model returns 0xBEEF:
  - cs_n/oe_n low exactly 3 cycles.
  - p0_rvalid 4 cycles after ack with rdata = 0xBEEF.
- p1 write 0x00010 <- 0x1234, cfg_wr_wait = 1:
  - Sequence SETUP 1, WE low 2, HOLD 1 cycle.
  - Address and DQ stable across the whole WE-low window.
  - No rvalid.
- Read then write back-to-back:
  - TURN cycle present.
  - Checker asserts padoe_sram_dq and !oe_n are never both set.
  - Write then read: DQ released on the first RD cycle.
- Both ports request reads continuously, 8 grants:
  - Fixed priority: all 8 to p1.
  - SRAM_CTRL_ROUND_ROBIN_EN: grants alternate p1, p0, p1, …
- rst_n asserted in the middle of WR_PULSE:
  - we_n = cs_n = 1 and padoe_sram_dq = 0 with no clock edge.
  - After release, a new read completes normally.
- cfg_rd_wait changed from 0 to 5 during an RD access: the in-flight access keeps 1 cycle; the next access uses 6.
